// File: rtl/fifo_uart_tx.sv
// FIFO drain side: pops one byte at a time and sends it as a UART frame.
// Optional even parity; byte_count tallies completed frames.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_dout,
  output logic        fifo_rd_en,
  output logic        tx,
  output logic        busy,
  output logic [15:0] byte_count
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_CAP,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          tx_q, tx_d;
  logic          busy_q;
  logic [15:0]   cnt_q, cnt_d;
  logic          last;

  assign last       = (baud_q == BAUD_LAST);
  assign fifo_rd_en = (state_q == S_REQ);
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign byte_count = cnt_q;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (enable && !fifo_empty) state_d = S_REQ;
      end
      S_REQ: state_d = S_CAP;
      S_CAP: begin
        shift_d = fifo_dout;
        par_d   = ^fifo_dout;
        baud_d  = '0;
        state_d = S_START;
      end
      S_START: begin
        if (last) begin
          baud_d  = '0;
          idx_d   = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_DATA: begin
        if (last) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7)
            state_d = PARITY_EN ? S_PAR : S_STOP;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_PAR: begin
        if (last) begin
          baud_d  = '0;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_STOP: begin
        if (last) begin
          baud_d  = '0;
          cnt_d   = cnt_q + 16'd1;
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line level follows the next state so tx is a clean flop output.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      S_PAR:   tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= (state_d != S_IDLE);
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench: two DUTs (no parity / parity) fed by small FIFO models.
// Frames are sampled mid-bit and timed against hand-computed lengths.
module tb_fifo_uart_tx;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en0 = 1'b0, en1 = 1'b0;
  logic        empty0, empty1;
  logic [7:0]  dout0, dout1;
  logic        rd0, rd1, tx0, tx1, busy0, busy1;
  logic [15:0] bc0, bc1;

  logic [7:0] mem0 [16];
  logic [7:0] mem1 [16];
  int wp0 = 0, rp0 = 0, wp1 = 0, rp1 = 0;
  int cyc = 0;
  int rdc0 = 0, wide0 = 0;
  logic rd0_prev = 1'b0;
  int nchk = 0, nfail = 0;

  always #5 clk = ~clk;

  assign empty0 = (wp0 == rp0);
  assign empty1 = (wp1 == rp1);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd0) begin
      dout0 <= mem0[rp0[3:0]];
      rp0   <= rp0 + 1;
      rdc0  <= rdc0 + 1;
      if (rd0_prev) wide0 <= wide0 + 1;
    end
    rd0_prev <= rd0;
    if (rd1) begin
      dout1 <= mem1[rp1[3:0]];
      rp1   <= rp1 + 1;
    end
  end

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) u0 (
    .clk(clk), .rst(rst), .enable(en0), .fifo_empty(empty0),
    .fifo_dout(dout0), .fifo_rd_en(rd0), .tx(tx0), .busy(busy0),
    .byte_count(bc0)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) u1 (
    .clk(clk), .rst(rst), .enable(en1), .fifo_empty(empty1),
    .fifo_dout(dout1), .fifo_rd_en(rd1), .tx(tx1), .busy(busy1),
    .byte_count(bc1)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push0(input logic [7:0] b);
    mem0[wp0[3:0]] = b;
    wp0++;
  endtask

  task automatic push1(input logic [7:0] b);
    mem1[wp1[3:0]] = b;
    wp1++;
  endtask

  function automatic logic txs(input int sel);
    return (sel == 1) ? tx1 : tx0;
  endfunction

  function automatic logic busys(input int sel);
    return (sel == 1) ? busy1 : busy0;
  endfunction

  // Waits for the start bit, samples each bit mid-cell, measures the frame.
  task automatic get_frame(input int sel, input bit drop,
                           output logic [7:0] d, output logic p,
                           output int t0, output int len);
    int n;
    d = '0; p = 1'b0; t0 = 0; len = 0;
    n = 0;
    while (txs(sel) !== 1'b0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("start_seen", 32'(n < 4000), 32'd1);
    if (n >= 4000) return;
    t0 = cyc;
    repeat (CPB / 2) @(negedge clk);
    check("start_bit", 32'(txs(sel)), 32'd0);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      d[i] = txs(sel);
      if (drop && i == 2) en0 = 1'b0;
    end
    if (sel == 1) begin
      repeat (CPB) @(negedge clk);
      p = txs(sel);
    end
    repeat (CPB) @(negedge clk);
    check("stop_bit", 32'(txs(sel)), 32'd1);
    n = 0;
    while (busys(sel) !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    len = cyc - t0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    logic p;
    int t1, t2, t3, len, base, n;

    // Reset with random enables; FIFO0 already holds 0xA5
    push0(8'hA5);
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      en0 = 1'($urandom);
      en1 = 1'($urandom);
      @(negedge clk);
      check("rst_tx", 32'(tx0), 32'd1);
      check("rst_rd", 32'(rd0), 32'd0);
      check("rst_busy", 32'(busy0), 32'd0);
      check("rst_bc", 32'(bc0), 32'd0);
      check("rst_tx1", 32'(tx1), 32'd1);
    end
    en0 = 1'b0;
    en1 = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_no_rd", 32'(rdc0), 32'd0);

    // Single byte 0xA5
    en0 = 1'b1;
    get_frame(0, 1'b0, d, p, t1, len);
    check("single_data", 32'(d), 32'hA5);
    check("single_len", 32'(len), 32'd160);
    check("single_bc", 32'(bc0), 32'd1);
    check("single_rd", 32'(rdc0), 32'd1);
    check("single_busy", 32'(busy0), 32'd0);

    // Parity frames on DUT1
    push1(8'h07);
    push1(8'h03);
    en1 = 1'b1;
    get_frame(1, 1'b0, d, p, t1, len);
    check("par07_data", 32'(d), 32'h07);
    check("par07_bit", 32'(p), 32'd1);
    check("par07_len", 32'(len), 32'd176);
    get_frame(1, 1'b0, d, p, t1, len);
    check("par03_data", 32'(d), 32'h03);
    check("par03_bit", 32'(p), 32'd0);
    check("par03_len", 32'(len), 32'd176);
    check("par_bc", 32'(bc1), 32'd2);

    // Back-to-back three bytes
    base = rdc0;
    push0(8'h11);
    push0(8'h22);
    push0(8'h33);
    get_frame(0, 1'b0, d, p, t1, len);
    check("b2b_d0", 32'(d), 32'h11);
    get_frame(0, 1'b0, d, p, t2, len);
    check("b2b_d1", 32'(d), 32'h22);
    check("b2b_gap1", 32'(t2 - t1 - 144), 32'd19);
    get_frame(0, 1'b0, d, p, t3, len);
    check("b2b_d2", 32'(d), 32'h33);
    check("b2b_gap2", 32'(t3 - t2 - 144), 32'd19);
    check("b2b_len", 32'(len), 32'd160);
    @(negedge clk);
    check("b2b_rd", 32'(rdc0 - base), 32'd3);
    check("b2b_wide", 32'(wide0), 32'd0);
    check("b2b_bc", 32'(bc0), 32'd4);
    check("b2b_empty", 32'(empty0), 32'd1);
    check("b2b_busy", 32'(busy0), 32'd0);

    // Enable dropped during DATA
    base = rdc0;
    push0(8'h81);
    push0(8'h42);
    get_frame(0, 1'b1, d, p, t1, len);
    check("drop_data", 32'(d), 32'h81);
    check("drop_len", 32'(len), 32'd160);
    repeat (100) @(negedge clk);
    check("drop_no_rd", 32'(rdc0 - base), 32'd1);
    check("drop_busy", 32'(busy0), 32'd0);
    check("drop_nonempty", 32'(empty0), 32'd0);
    en0 = 1'b1;
    get_frame(0, 1'b0, d, p, t1, len);
    check("reen_data", 32'(d), 32'h42);
    check("reen_rd", 32'(rdc0 - base), 32'd2);
    check("reen_bc", 32'(bc0), 32'd6);

    // Reset during data bit 4
    push0(8'h5A);
    push0(8'h3C);
    n = 0;
    while (tx0 !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("mid_start_seen", 32'(n < 100), 32'd1);
    repeat (CPB * 5 + CPB / 2) @(negedge clk);
    check("mid_busy_before", 32'(busy0), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("mid_tx", 32'(tx0), 32'd1);
    check("mid_busy", 32'(busy0), 32'd0);
    check("mid_rd", 32'(rd0), 32'd0);
    check("mid_bc", 32'(bc0), 32'd0);
    repeat (2) @(negedge clk);
    base = rdc0;
    rst = 1'b1;
    get_frame(0, 1'b0, d, p, t1, len);
    check("post_data", 32'(d), 32'h3C);
    check("post_rd", 32'(rdc0 - base), 32'd1);
    check("post_bc", 32'(bc0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
